// File: rtl/ps2_key_receiver_pkg.sv
// ps2_key_receiver_pkg: set-2 prefix codes, receiver FSM states and key event layout
package ps2_key_receiver_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam int EVENT_W = 10;
    typedef enum logic [1:0] {PS2_IDLE, PS2_DATA, PS2_PARITY, PS2_STOP} ps2State_t;
    typedef struct packed {
        logic keyRelease;
        logic keyExtended;
        logic [7:0] keyCode;
    } keyEvent_t;
    function automatic logic isPrefix(input logic [7:0] b);
        return b == PS2_BREAK || b == PS2_EXT;
    endfunction
endpackage

// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: key event stream from the PS/2 receiver to the core
interface ps2_key_receiver_if;
    logic iPop;
    logic oValid;
    logic [7:0] oKeyCode;
    logic oKeyRelease;
    logic oKeyExtended;
    logic oFrameError;
    logic oOverflow;
    modport master(input iPop, output oValid, oKeyCode, oKeyRelease, oKeyExtended, oFrameError, oOverflow);
    modport slave(output iPop, input oValid, oKeyCode, oKeyRelease, oKeyExtended, oFrameError, oOverflow);
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous show-ahead FIFO with registered occupancy count
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oEmpty,
    output logic             oFull
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count;
    logic doPush, doPop;
    assign oEmpty = count == '0;
    assign oFull = count == CW'(DEPTH);
    assign doPop = iPop && !oEmpty;
    assign doPush = iPush && (!oFull || doPop);
    assign oData = oEmpty ? '0 : mem[rdPtr];
    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= iData;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: filtered PS/2 frame receiver with set-2 prefix decoding into an event FIFO
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic Clock,
    input logic Reset,
    input logic iPS2Clk,
    input logic iPS2Data,
    ps2_key_receiver_if.master kbd
);
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [1:0] clkSync, dataSync;
    logic filtClk, clkDiffers, filtDone, sample, dataBit;
    logic [FW-1:0] filtCnt;
    ps2State_t state, stateNext;
    logic [2:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftNext;
    logic parityErr, parityErrNext;
    logic [TW-1:0] wdCnt, wdNext;
    logic goodByte, badFrame, push, popNow, fifoEmpty, fifoFull;
    logic relPend, extPend;
    keyEvent_t head;
    assign clkDiffers = clkSync[1] != filtClk;
    assign filtDone = clkDiffers && filtCnt == FW'(FILTER_LEN - 1);
    assign sample = filtDone && !clkSync[1];
    assign dataBit = dataSync[1];
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clkSync <= 2'b11;
            dataSync <= 2'b11;
            filtClk <= 1'b1;
            filtCnt <= '0;
            relPend <= 1'b0;
            extPend <= 1'b0;
            kbd.oFrameError <= 1'b0;
            kbd.oOverflow <= 1'b0;
        end else begin
            clkSync <= {clkSync[0], iPS2Clk};
            dataSync <= {dataSync[0], iPS2Data};
            filtCnt <= (clkDiffers && !filtDone) ? filtCnt + 1'b1 : '0;
            if (filtDone) filtClk <= clkSync[1];
            if (goodByte) begin
                relPend <= shiftReg == PS2_BREAK || (shiftReg == PS2_EXT && relPend);
                extPend <= shiftReg == PS2_EXT || (shiftReg == PS2_BREAK && extPend);
            end
            kbd.oFrameError <= badFrame;
            kbd.oOverflow <= kbd.oOverflow || (push && fifoFull && !popNow);
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= PS2_IDLE;
            bitCnt <= '0;
            shiftReg <= '0;
            parityErr <= 1'b0;
            wdCnt <= '0;
        end else begin
            state <= stateNext;
            bitCnt <= bitCntNext;
            shiftReg <= shiftNext;
            parityErr <= parityErrNext;
            wdCnt <= wdNext;
        end
    end
    always_comb begin
        stateNext = state;
        bitCntNext = bitCnt;
        shiftNext = shiftReg;
        parityErrNext = parityErr;
        wdNext = '0;
        goodByte = 1'b0;
        badFrame = 1'b0;
        case (state)
            PS2_IDLE: if (sample && !dataBit) begin
                stateNext = PS2_DATA;
                bitCntNext = '0;
            end
            PS2_DATA: if (sample) begin
                shiftNext = {dataBit, shiftReg[7:1]};
                bitCntNext = bitCnt + 1'b1;
                stateNext = bitCnt == 3'd7 ? PS2_PARITY : PS2_DATA;
            end
            PS2_PARITY: if (sample) begin
                parityErrNext = ~(^shiftReg ^ dataBit);
                stateNext = PS2_STOP;
            end
            default: if (sample) begin
                goodByte = dataBit && !parityErr;
                badFrame = !goodByte;
                stateNext = PS2_IDLE;
            end
        endcase
        // A stalled frame is dropped; prefix flags survive so a retransmit still decodes.
        if (state != PS2_IDLE && !sample) begin
            if (wdCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                stateNext = PS2_IDLE;
                badFrame = 1'b1;
            end else begin
                wdNext = wdCnt + 1'b1;
            end
        end
    end
    assign push = goodByte && !isPrefix(shiftReg);
    assign popNow = kbd.iPop && !fifoEmpty;
    ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVENT_W)) fifo (
        .Clock(Clock),
        .Reset(Reset),
        .iPush(push),
        .iData({relPend, extPend, shiftReg}),
        .iPop(kbd.iPop),
        .oData(head),
        .oEmpty(fifoEmpty),
        .oFull(fifoFull)
    );
    assign kbd.oValid = !fifoEmpty;
    assign kbd.oKeyCode = head.keyCode;
    assign kbd.oKeyRelease = head.keyRelease;
    assign kbd.oKeyExtended = head.keyExtended;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: scenario and randomized checks of the PS/2 receiver against a key-event queue model
module tb_ps2_key_receiver;
    localparam int FIFO_DEPTH = 4;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int HALF = 8;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic ps2Clk = 1'b1;
    logic ps2Data = 1'b1;
    ps2_key_receiver_if kbd();
    ps2_key_receiver #(.FIFO_DEPTH(FIFO_DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iPS2Clk(ps2Clk),
        .iPS2Data(ps2Data),
        .kbd(kbd)
    );
    always #5 Clock = ~Clock;
    int checks = 0;
    int errors = 0;
    int errPulses = 0;
    int mErr = 0;
    logic [9:0] q[$];
    logic mRel = 1'b0, mExt = 1'b0, mOvf = 1'b0;
    always @(posedge Clock) if (kbd.oFrameError === 1'b1) errPulses++;
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask
    function automatic logic [10:0] frameBits(input logic [7:0] b, input logic badPar, input logic stopBit);
        return {stopBit, (~^b) ^ badPar, b, 1'b0};
    endfunction
    function automatic logic [11:0] modelView();
        return {q.size() != 0, mOvf, q.size() != 0 ? q[0] : 10'h0};
    endfunction
    function automatic logic [11:0] dutView();
        return {kbd.oValid, kbd.oOverflow, kbd.oKeyRelease, kbd.oKeyExtended, kbd.oKeyCode};
    endfunction
    task automatic modelFrame(input logic [7:0] b, input logic ok);
        if (!ok) mErr++;
        else if (b == 8'hF0) mRel = 1'b1;
        else if (b == 8'hE0) mExt = 1'b1;
        else begin
            if (q.size() < FIFO_DEPTH) q.push_back({mRel, mExt, b});
            else mOvf = 1'b1;
            mRel = 1'b0;
            mExt = 1'b0;
        end
    endtask
    task automatic sendBit(input logic b);
        ps2Data = b;
        repeat (HALF) tick();
        ps2Clk = 1'b0;
        repeat (HALF) tick();
        ps2Clk = 1'b1;
    endtask
    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) sendBit(bits[i]);
    endtask
    task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic stopBit);
        sendBits(frameBits(b, badPar, stopBit), 11);
        modelFrame(b, !badPar && stopBit);
    endtask
    task automatic toStopFall(input logic [10:0] bits);
        sendBits(bits, 10);
        ps2Data = bits[10];
        repeat (HALF) tick();
        ps2Clk = 1'b0;
        repeat (FILTER_LEN + 1) tick();
    endtask
    task automatic finishStop();
        repeat (HALF - FILTER_LEN - 2) tick();
        ps2Clk = 1'b1;
    endtask
    task automatic popOne();
        kbd.iPop = 1'b1;
        tick();
        kbd.iPop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask
    task automatic test_reset();
        kbd.iPop = 1'b0;
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (dutView() !== 12'h0 || kbd.oFrameError !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h err %b expected 000 err 0", dutView(), kbd.oFrameError);
        end
    endtask
    task automatic test_make();
        toStopFall(frameBits(8'h1C, 1'b0, 1'b1));
        checks++;
        if (kbd.oValid !== 1'b0) begin
            errors++;
            $display("FAIL make_early: oValid %b expected 0 one edge before push", kbd.oValid);
        end
        tick();
        modelFrame(8'h1C, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL make_head: got %h expected %h", dutView(), modelView());
        end
        finishStop();
        popOne();
        checks++;
        if (kbd.oValid !== 1'b0) begin
            errors++;
            $display("FAIL make_pop: oValid %b expected 0", kbd.oValid);
        end
    endtask
    task automatic test_break_ext();
        sendFrame(8'hF0, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL break_prefix: got %h expected %h", dutView(), modelView());
        end
        sendFrame(8'h1C, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL break_event: got %h expected %h", dutView(), modelView());
        end
        popOne();
        sendFrame(8'hE0, 1'b0, 1'b1);
        sendFrame(8'hF0, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL ext_prefixes: got %h expected %h", dutView(), modelView());
        end
        sendFrame(8'h75, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL ext_event: got %h expected %h", dutView(), modelView());
        end
        popOne();
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL ext_pop: got %h expected %h", dutView(), modelView());
        end
    endtask
    task automatic test_parity_glitch();
        sendFrame(8'h1C, 1'b1, 1'b1);
        checks++;
        if (errPulses !== mErr || dutView() !== modelView()) begin
            errors++;
            $display("FAIL parity_error: pulses %0d view %h expected pulses %0d view %h", errPulses, dutView(), mErr, modelView());
        end
        ps2Data = 1'b0;
        ps2Clk = 1'b0;
        repeat (2) tick();
        ps2Clk = 1'b1;
        repeat (20) tick();
        sendFrame(8'h32, 1'b0, 1'b1);
        checks++;
        if (errPulses !== mErr || dutView() !== modelView()) begin
            errors++;
            $display("FAIL glitch_then_32: pulses %0d view %h expected pulses %0d view %h", errPulses, dutView(), mErr, modelView());
        end
        popOne();
    endtask
    task automatic test_overflow();
        sendFrame(8'h15, 1'b0, 1'b1);
        sendFrame(8'h1D, 1'b0, 1'b1);
        sendFrame(8'h24, 1'b0, 1'b1);
        sendFrame(8'h2D, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL fill_four: got %h expected %h", dutView(), modelView());
        end
        toStopFall(frameBits(8'h3C, 1'b0, 1'b1));
        popOne();
        modelFrame(8'h3C, 1'b1);
        finishStop();
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL full_push_pop: got %h expected %h", dutView(), modelView());
        end
        sendFrame(8'h2C, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL overflow_set: got %h expected %h", dutView(), modelView());
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            popOne();
            checks++;
            if (dutView() !== modelView()) begin
                errors++;
                $display("FAIL overflow_pop%0d: got %h expected %h", i, dutView(), modelView());
            end
        end
    endtask
    task automatic test_timeout();
        int n;
        sendBits(frameBits(8'h1C, 1'b0, 1'b1), 4);
        n = 0;
        while (kbd.oFrameError !== 1'b1 && n < TIMEOUT_CYCLES + 100) begin
            tick();
            n++;
        end
        mErr++;
        checks++;
        if (n != FILTER_LEN + 2 + TIMEOUT_CYCLES - HALF) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles expected %0d", n, FILTER_LEN + 2 + TIMEOUT_CYCLES - HALF);
        end
        repeat (4) tick();
        sendFrame(8'h1C, 1'b0, 1'b1);
        checks++;
        if (errPulses !== mErr || dutView() !== modelView()) begin
            errors++;
            $display("FAIL timeout_recover: pulses %0d view %h expected pulses %0d view %h", errPulses, dutView(), mErr, modelView());
        end
    endtask
    task automatic test_reset_midframe();
        sendBits(frameBits(8'h4B, 1'b0, 1'b1), 5);
        Reset = 1'b1;
        tick();
        checks++;
        if (dutView() !== 12'h0 || kbd.oFrameError !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h err %b expected 000 err 0", dutView(), kbd.oFrameError);
        end
        Reset = 1'b0;
        q.delete();
        mRel = 1'b0;
        mExt = 1'b0;
        mOvf = 1'b0;
        repeat (30) tick();
        checks++;
        if (errPulses !== mErr) begin
            errors++;
            $display("FAIL reset_no_error: pulses %0d expected %0d", errPulses, mErr);
        end
        sendFrame(8'h4B, 1'b0, 1'b1);
        checks++;
        if (dutView() !== modelView()) begin
            errors++;
            $display("FAIL reset_recover: got %h expected %h", dutView(), modelView());
        end
    endtask
    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = r == 0 ? 8'hF0 : r == 1 ? 8'hE0 : 8'($urandom_range(0, 255));
            sendFrame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0);
            checks++;
            if (errPulses !== mErr || dutView() !== modelView()) begin
                errors++;
                $display("FAIL random_frame%0d byte %h: pulses %0d view %h expected pulses %0d view %h", i, b, errPulses, dutView(), mErr, modelView());
            end
            if ($urandom_range(0, 2) != 0) begin
                popOne();
                checks++;
                if (dutView() !== modelView()) begin
                    errors++;
                    $display("FAIL random_pop%0d: got %h expected %h", i, dutView(), modelView());
                end
            end
        end
    endtask
    initial begin
        test_reset();
        test_make();
        test_break_ext();
        test_parity_glitch();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
